// File: rtl/cpu6_ifu_pkg.sv
// Shared CPU6 width/depth/NOP constants and the fetch-buffer entry type.
// The `CPU6_* macros are visible to every file compiled after this one.
`ifndef CPU6_DEFINES_V
`define CPU6_DEFINES_V
`define CPU6_XLEN      32
`define CPU6_IFU_DEPTH 2
`define CPU6_NOP       32'h0000_0013
`endif

package cpu6_ifu_pkg;
    localparam int XLEN      = `CPU6_XLEN;
    localparam int IFU_DEPTH = `CPU6_IFU_DEPTH;
    localparam int CNT_W     = $clog2(IFU_DEPTH + 1);
    localparam logic [XLEN-1:0] NOP_INSTR = `CPU6_NOP;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifu_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/cpu6_ifu_fifo.sv
// Small instruction buffer: register-array FIFO with flush, head always visible
// on rdata_o. Flush wins over push and pop.
module cpu6_ifu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop);

    always_ff @(posedge clk) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
endmodule

// File: rtl/cpu6_ifu.sv
// CPU6 instruction fetch unit: issues word fetches, tracks in-flight and
// to-be-dropped responses, and buffers returned instructions for decode.
module cpu6_ifu
    import cpu6_ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata
);
    logic [XLEN-1:0]  fpc_q, fpc_d, rsp_pc_q, rsp_pc_d, addr_q;
    logic             pend_q, stale_q, stale_d;
    logic [1:0]       live_q, live_d, drop_q, drop_d, live_after, drop_after;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_valid, pop, fire, fire_live, fire_stale, rv_live, rv_drop, issue_ok;
    logic [2:0]       occupancy;
    ifu_entry_t       head, push_entry;

    // Dropped responses still occupy memory slots, so they count against the
    // buffer budget; this also bounds live+drop to DEPTH and keeps both counters from wrapping.
    always_comb begin
        pop        = fifo_valid & instr_ready;
        occupancy  = 3'(fifo_count) + 3'(live_q) + 3'(drop_q);
        issue_ok   = occupancy < (3'(IFU_DEPTH) + 3'(pop));
        imem_req   = reset & (pend_q | issue_ok);
        imem_addr  = pend_q ? addr_q : fpc_q;
        fire       = imem_req & imem_gnt;
        fire_stale = fire & stale_q;
        fire_live  = fire & ~stale_q;
        rv_drop    = imem_rvalid & (drop_q != 2'd0);
        rv_live    = imem_rvalid & (drop_q == 2'd0);
        live_after = live_q + {1'b0, fire_live} - {1'b0, rv_live};
        drop_after = drop_q + {1'b0, fire_stale} - {1'b0, rv_drop};
        push_entry = '{pc: rsp_pc_q, instr: imem_rdata};

        fpc_d    = fire_live ? fpc_q + XLEN'(4) : fpc_q;
        rsp_pc_d = rv_live ? rsp_pc_q + XLEN'(4) : rsp_pc_q;
        live_d   = live_after;
        drop_d   = drop_after;
        stale_d  = fire ? 1'b0 : stale_q;
        if (redirect_valid) begin
            fpc_d    = word_align(redirect_pc);
            rsp_pc_d = word_align(redirect_pc);
            live_d   = 2'd0;
            drop_d   = drop_after + live_after;
            stale_d  = imem_req & ~imem_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fpc_q    <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            addr_q   <= '0;
            pend_q   <= 1'b0;
            stale_q  <= 1'b0;
            live_q   <= 2'd0;
            drop_q   <= 2'd0;
        end else begin
            fpc_q    <= fpc_d;
            rsp_pc_q <= rsp_pc_d;
            addr_q   <= imem_addr;
            pend_q   <= imem_req & ~imem_gnt;
            stale_q  <= stale_d;
            live_q   <= live_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && imem_rvalid) assert (live_q != 2'd0 || drop_q != 2'd0);
    end

    cpu6_ifu_fifo #(
        .WIDTH ($bits(ifu_entry_t)),
        .DEPTH (IFU_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_ni  (reset),
        .flush_i (redirect_valid),
        .push_i  (rv_live),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign instr_valid = fifo_valid;
    assign instr       = fifo_valid ? head.instr : NOP_INSTR;
    assign instr_pc    = fifo_valid ? head.pc : '0;
endmodule

// File: tb/tb_cpu6_ifu.sv
// Randomised bench for cpu6_ifu: an in-order memory model with random grant and
// latency, and a reference of the expected program-order PC stream.
module tb_cpu6_ifu;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr, instr_pc;
    logic        instr_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;

    cpu6_ifu #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } rsp_t;
    rsp_t        rq[$];
    logic [31:0] gaddr[$];
    logic [31:0] acc[$];
    int          n_cmp = 0, n_bad = 0;
    int          cyc, last_due, lat_min, lat_max, n_grant, first_acc_cyc, n_acc_total;
    logic [31:0] exp_pc, prev_addr;
    bit          prev_pend, post_redir, t_req;
    logic [31:0] t_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", instr_pc, 0);
        chk("rst_req", 32'(imem_req), 0);
        rq.delete(); gaddr.delete(); acc.delete();
        cyc = 0; last_due = 0; exp_pc = 32'h0; n_grant = 0; first_acc_cyc = -1;
        prev_pend = 1'b0; post_redir = 1'b0;
    endtask

    // One clock cycle: drive inputs, act as memory, check the decode-side stream.
    task automatic tick(input bit rdy, input bit redir, input logic [31:0] tgt, input int gmode);
        int due;
        @(negedge clk);
        cyc++;
        reset = 1'b1;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mdata(rq[0].addr);
            void'(rq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        instr_ready = rdy; redirect_valid = redir; redirect_pc = tgt;
        #1;
        t_req = imem_req; t_addr = imem_addr;
        if (prev_pend) begin
            chk("req_hold", 32'(imem_req), 1);
            chk("addr_hold", imem_addr, prev_addr);
        end
        imem_gnt = imem_req && (gmode == 1 || (gmode == 2 && $urandom_range(0, 2) != 0));
        if (imem_req && imem_gnt) begin
            chk("addr_align", 32'(imem_addr[1:0]), 0);
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            rq.push_back('{addr: imem_addr, due: due});
            gaddr.push_back(imem_addr);
            n_grant++;
        end
        prev_pend = imem_req && !imem_gnt;
        prev_addr = imem_addr;
        if (post_redir) chk("valid_after_redir", 32'(instr_valid), 0);
        if (instr_valid && rdy && !redir) begin
            chk("instr_pc", instr_pc, exp_pc);
            chk("instr", instr, mdata(exp_pc));
            acc.push_back(instr_pc);
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            exp_pc = exp_pc + 32'd4;
            n_acc_total++;
        end
        if (redir) exp_pc = tgt & 32'hFFFF_FFFC;
        post_redir = redir;
        chk("outstanding_le2", 32'(rq.size() <= 2), 1);
    endtask

    initial begin
        int r;
        n_acc_total = 0;
        lat_min = 1; lat_max = 1;

        // Back-to-back streaming.
        do_reset();
        tick(1, 0, 0, 1);
        chk("first_req", 32'(t_req), 1);
        chk("first_addr", t_addr, 0);
        repeat (7) tick(1, 0, 0, 1);
        chk("thru_first_cyc", first_acc_cyc, 3);
        chk("thru_count", acc.size(), 6);

        // Decode stalled: buffer fills, fetch stops, then resumes losslessly.
        do_reset();
        repeat (6) tick(0, 0, 0, 1);
        chk("stall_grants", n_grant, 2);
        chk("stall_req", 32'(t_req), 0);
        repeat (6) tick(1, 0, 0, 1);
        chk("resume_count", acc.size(), 6);

        // Grant withheld: request and address held, pointer waits for gnt.
        do_reset();
        repeat (3) begin
            tick(1, 0, 0, 0);
            chk("nognt_req", 32'(t_req), 1);
            chk("nognt_addr", t_addr, 0);
        end
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 1);
        chk("gnt_count", gaddr.size(), 2);
        if (gaddr.size() >= 2) chk("gnt_addr1", gaddr[1], 4);

        // Redirect with two requests in flight.
        do_reset();
        lat_min = 3; lat_max = 3;
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 1);
        chk("inflight_before_redir", rq.size(), 2);
        tick(1, 1, 32'h100, 1);
        repeat (10) tick(1, 0, 0, 1);
        chk("redir_acc_n", 32'(acc.size() >= 2), 1);
        if (acc.size() >= 2) begin
            chk("redir_pc0", acc[0], 32'h100);
            chk("redir_pc1", acc[1], 32'h104);
        end

        // Redirect while a request is pending un-granted (also pop+rvalid same cycle).
        do_reset();
        lat_min = 1; lat_max = 1;
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 1);
        tick(1, 1, 32'h203, 0);
        chk("stale_req", 32'(t_req), 1);
        chk("stale_addr", t_addr, 8);
        tick(1, 0, 0, 1);
        chk("stale_gnt_addr", t_addr, 8);
        tick(1, 0, 0, 1);
        chk("new_stream_addr", t_addr, 32'h200);
        repeat (4) tick(1, 0, 0, 1);
        chk("stale_acc_n", 32'(acc.size() >= 1), 1);
        if (acc.size() >= 1) chk("stale_acc_pc0", acc[0], 32'h200);

        // Random traffic with occasional redirects and mid-run resets.
        do_reset();
        lat_min = 1; lat_max = 3;
        n_acc_total = 0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 15);
            tick($urandom_range(0, 3) != 0, r == 0, $urandom & 32'h0000_0FFF, 2);
            if (r == 1 && $urandom_range(0, 20) == 0) do_reset();
        end
        chk("random_progress", 32'(n_acc_total > 400), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
